// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
//
// Purpose: grants at most one requester per cycle (round-robin on last_gnt),
// supports a lock that keeps ownership with one requester across an atomic
// sequence, and routes the one-cycle-late RAM read data back to whichever
// requester issued the read.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mN_req/we/lock/addr/wdata requester N command (N = 0, 1)
//   mN_gnt                   access accepted this cycle (combinational)
//   mN_rvalid/rdata          read return, one cycle after a read grant
//   mem_addr/wdata/wen/ren   RAM command, driven from the winner only
//   mem_rdata                RAM read data, valid one cycle after mem_ren
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // last_gnt: 0 = m0 won most recently, 1 = m1.
    logic last_gnt_q, last_gnt_d;
    logic owner_valid_q, owner_valid_d;
    logic owner_q, owner_d;
    logic rvalid0_q, rvalid0_d;
    logic rvalid1_q, rvalid1_d;

    logic elig0, elig1;
    logic owner_lock;
    logic win_lock;

    // Arbitration uses only req, lock state and last_gnt; no gnt feedback.
    always_comb begin
        elig0  = m0_req && (!owner_valid_q || !owner_q);
        elig1  = m1_req && (!owner_valid_q ||  owner_q);
        m0_gnt = !rst && elig0 && (!elig1 ||  last_gnt_q);
        m1_gnt = !rst && elig1 && (!elig0 || !last_gnt_q);
    end

    // RAM command mux: zeros whenever nobody is granted.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        if (m0_gnt) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_wen   = m0_we;
            mem_ren   = !m0_we;
        end else if (m1_gnt) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wen   = m1_we;
            mem_ren   = !m1_we;
        end
    end

    // Next-state for round-robin pointer, lock ownership and read tracking.
    always_comb begin
        last_gnt_d    = last_gnt_q;
        owner_valid_d = owner_valid_q;
        owner_d       = owner_q;
        owner_lock    = owner_q ? m1_lock : m0_lock;
        win_lock      = m1_gnt ? m1_lock : m0_lock;

        // While locked only the owner is granted, so last_gnt stays at the
        // owner and the blocked requester wins the first contention after release.
        if (m0_gnt) last_gnt_d = 1'b0;
        if (m1_gnt) last_gnt_d = 1'b1;

        // Owner dropping lock releases next cycle; this also covers the owner
        // being granted with lock low.
        if (owner_valid_q && !owner_lock) owner_valid_d = 1'b0;

        if ((m0_gnt || m1_gnt) && win_lock) begin
            owner_valid_d = 1'b1;
            owner_d       = m1_gnt;
        end

        rvalid0_d = m0_gnt && !m0_we;
        rvalid1_d = m1_gnt && !m1_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q    <= 1'b1;
            owner_valid_q <= 1'b0;
            owner_q       <= 1'b0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
        end else begin
            last_gnt_q    <= last_gnt_d;
            owner_valid_q <= owner_valid_d;
            owner_q       <= owner_d;
            rvalid0_q     <= rvalid0_d;
            rvalid1_q     <= rvalid1_d;
        end
    end

    // Gating with rst drops a read granted the cycle before reset asserts.
    always_comb begin
        m0_rvalid = rvalid0_q && !rst;
        m1_rvalid = rvalid1_q && !rst;
        m0_rdata  = m0_rvalid ? mem_rdata : '0;
        m1_rdata  = m1_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_wen, mem_ren;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ram [logic [31:0]];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata)
    );

    // Synchronous single-port RAM model.
    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] = mem_wdata;
        if (mem_ren) mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    // Inputs change just after the rising edge; checks run at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        idle();
        rst = 1;
        next_cycle();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        mem_rdata = 0;
        ram[32'h0001_0004] = 32'hDEAD_BEEF;
        ram[32'h0000_0100] = 32'hA0A0_0100;
        ram[32'h0000_0200] = 32'hB0B0_0200;

        // Reset: grants and RAM strobes forced low even with requests pending.
        next_cycle();
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        check("rst_m0_gnt", {31'b0, m0_gnt}, 0);
        check("rst_m1_gnt", {31'b0, m1_gnt}, 0);
        check("rst_mem_ren", {31'b0, mem_ren}, 0);
        check("rst_mem_wen", {31'b0, mem_wen}, 0);
        check("rst_m0_rvalid", {31'b0, m0_rvalid}, 0);
        next_cycle();
        idle();
        rst = 0;

        // Single read from m0.
        m0_req = 1; m0_addr = 32'h0001_0004;
        @(negedge clk);
        check("rd_m0_gnt", {31'b0, m0_gnt}, 1);
        check("rd_m1_gnt", {31'b0, m1_gnt}, 0);
        check("rd_mem_ren", {31'b0, mem_ren}, 1);
        check("rd_mem_wen", {31'b0, mem_wen}, 0);
        check("rd_mem_addr", mem_addr, 32'h0001_0004);
        next_cycle();
        idle();
        @(negedge clk);
        check("rd_m0_rvalid", {31'b0, m0_rvalid}, 1);
        check("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("rd_m1_rvalid", {31'b0, m1_rvalid}, 0);
        check("rd_m1_rdata", m1_rdata, 0);
        check("idle_mem_ren", {31'b0, mem_ren}, 0);
        check("idle_mem_addr", mem_addr, 0);

        // Contention after reset: strict alternation starting with m0.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            m0_req = 1; m0_addr = 32'h100;
            m1_req = 1; m1_addr = 32'h200;
            @(negedge clk);
            check($sformatf("rr%0d_m0_gnt", k), {31'b0, m0_gnt}, (k % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_m1_gnt", k), {31'b0, m1_gnt}, (k % 2 == 1) ? 1 : 0);
            if (k > 0) begin
                check($sformatf("rr%0d_m0_rvalid", k), {31'b0, m0_rvalid}, (k % 2 == 1) ? 1 : 0);
                check($sformatf("rr%0d_m1_rvalid", k), {31'b0, m1_rvalid}, (k % 2 == 0) ? 1 : 0);
                check($sformatf("rr%0d_rdata", k), m0_rdata | m1_rdata,
                      (k % 2 == 1) ? 32'hA0A0_0100 : 32'hB0B0_0200);
            end
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("rr_tail_m1_rvalid", {31'b0, m1_rvalid}, 1);
        check("rr_tail_m1_rdata", m1_rdata, 32'hB0B0_0200);
        check("rr_tail_m0_rvalid", {31'b0, m0_rvalid}, 0);
        next_cycle();

        // Write then read-back from m1 on consecutive cycles.
        m1_req = 1; m1_we = 1; m1_addr = 32'h0001_0010; m1_wdata = 32'h1234_5678;
        @(negedge clk);
        check("wr_m1_gnt", {31'b0, m1_gnt}, 1);
        check("wr_mem_wen", {31'b0, mem_wen}, 1);
        check("wr_mem_ren", {31'b0, mem_ren}, 0);
        check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        next_cycle();
        m1_we = 0; m1_wdata = 0;
        @(negedge clk);
        check("wrrd_mem_ren", {31'b0, mem_ren}, 1);
        check("wrrd_mem_wen", {31'b0, mem_wen}, 0);
        check("wr_no_rvalid", {31'b0, m1_rvalid}, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("wrrd_m1_rvalid", {31'b0, m1_rvalid}, 1);
        check("wrrd_m1_rdata", m1_rdata, 32'h1234_5678);
        next_cycle();

        // Lock: m0 takes ownership (last_gnt = m1 so m0 wins), m1 blocked.
        m0_req = 1; m0_we = 1; m0_lock = 1; m0_addr = 32'h300; m0_wdata = 32'h5;
        m1_req = 1; m1_addr = 32'h200;
        @(negedge clk);
        check("lk0_m0_gnt", {31'b0, m0_gnt}, 1);
        check("lk0_m1_gnt", {31'b0, m1_gnt}, 0);
        next_cycle();
        m0_req = 0; m0_we = 0;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("lk%0d_m1_blocked", k), {31'b0, m1_gnt}, 0);
            next_cycle();
        end
        m0_lock = 0;
        @(negedge clk);
        check("lkfall_m1_gnt", {31'b0, m1_gnt}, 0);
        check("lkfall_mem_ren", {31'b0, mem_ren}, 0);
        next_cycle();
        m0_req = 1; m0_addr = 32'h100;
        @(negedge clk);
        check("lkrel_m1_gnt", {31'b0, m1_gnt}, 1);
        check("lkrel_m0_gnt", {31'b0, m0_gnt}, 0);
        next_cycle();
        idle();

        // Reset mid-operation: read granted, then rst before rvalid.
        m0_req = 1; m0_addr = 32'h100;
        @(negedge clk);
        check("rstmid_m0_gnt", {31'b0, m0_gnt}, 1);
        next_cycle();
        rst = 1;
        m1_req = 1; m1_addr = 32'h200;
        @(negedge clk);
        check("rstmid_m0_rvalid", {31'b0, m0_rvalid}, 0);
        check("rstmid_m0_rdata", m0_rdata, 0);
        check("rstmid_m0_gnt_off", {31'b0, m0_gnt}, 0);
        check("rstmid_m1_gnt_off", {31'b0, m1_gnt}, 0);
        check("rstmid_mem_ren", {31'b0, mem_ren}, 0);
        next_cycle();
        rst = 0;
        @(negedge clk);
        check("post_rst_m0_gnt", {31'b0, m0_gnt}, 1);
        check("post_rst_m1_gnt", {31'b0, m1_gnt}, 0);
        check("post_rst_m0_rvalid", {31'b0, m0_rvalid}, 0);
        next_cycle();
        idle();
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning requester/memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports mN_req  input  1  access request, for N = 0 and N = 1.
REQ-006 SHALL have ports mN_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports mN_lock  input  1  hold ownership after this grant (atomic sequence).
REQ-008 SHALL have ports mN_addr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have ports mN_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have ports mN_gnt  output  1  access accepted this cycle.
REQ-011 SHALL have ports mN_rvalid  output  1  read data valid.
REQ-012 SHALL have ports mN_rdata  output  DATA_WIDTH  read data.
REQ-013 SHALL have port mem_addr  output  ADDR_WIDTH  address to the single-port synchronous RAM.
REQ-014 SHALL have port mem_wdata  output  DATA_WIDTH  write data to the RAM.
REQ-015 SHALL have port mem_wen  output  1  RAM write enable.
REQ-016 SHALL have port mem_ren  output  1  RAM read enable.
REQ-017 SHALL have port mem_rdata  input  DATA_WIDTH  RAM read data, valid one cycle after mem_ren.

Function
REQ-018 SHALL grant at most one requester per cycle; gnt is combinational in the cycle the access is issued.
- Requesters hold req, we, addr and wdata stable until gnt.
REQ-019 SHALL, in a grant cycle, drive mem_addr/mem_wdata from the winner, with mem_wen = winner_we and mem_ren = !winner_we.
- In non-grant cycles: mem_wen = mem_ren = 0, mem_addr = mem_wdata = 0.
REQ-020 SHALL sustain back-to-back grants, one per cycle, to either requester without idle cycles.
REQ-021 SHALL assert mN_rvalid for exactly one cycle, in the cycle after a read grant to mN.
- mN_rdata = mem_rdata while mN_rvalid = 1, else 0.
- Writes produce no rvalid.
REQ-022 SHALL arbitrate round-robin using register last_gnt:
- Single requester: it wins.
- Both requesting: the one not equal to last_gnt wins.
- last_gnt updates to the winner on every grant.
REQ-023 SHALL implement lock:
- Register owner_valid/owner is set to the winner when granted with lock = 1.
- While owner_valid, only owner may be granted; the other requester waits even if owner is idle.
REQ-024 SHALL clear owner_valid:
- In any cycle the owner's lock input is 0, effective next cycle.
- In the same cycle the owner is granted with lock = 0.
REQ-025 SHALL, while locked, not advance last_gnt from the blocked requester's perspective.
- After release, a pending requester that was blocked wins the next contended cycle.
REQ-026 SHALL give both requesting simultaneously with no lock a strict alternation 0,1,0,1...
REQ-027 SHALL keep the arbitration path free of combinational loops: gnt depends only on req, lock state and last_gnt, never on gnt.

Reset
REQ-028 SHALL, while rst = 1, force m0_gnt = m1_gnt = 0 and mem_wen = mem_ren = 0.
REQ-029 SHALL reset to: last_gnt = 1 (m0 wins first contention), owner_valid = 0, mN_rvalid = 0, mN_rdata = 0.
REQ-030 SHALL discard a read granted in the cycle before rst asserts: no rvalid is produced during or after reset.

Verification
REQ-031 Single read: m0 read 0x00010004, RAM returns 0xDEADBEEF -> m0_gnt = 1 in cycle N, mem_ren = 1; m0_rvalid = 1 and m0_rdata = 0xDEADBEEF in cycle N+1; m1 outputs 0.
REQ-032 Contention after reset: both request reads every cycle for 4 cycles -> grants m0,m1,m0,m1; rvalid alternates one cycle later.
REQ-033 Write/read pipeline: m1 writes 0x12345678 to 0x00010010, then reads it the next cycle -> mem_wen then mem_ren on consecutive cycles; m1_rvalid with 0x12345678.
REQ-034 Lock: m0 granted with lock = 1, m1 requesting, m0 holds lock for 3 cycles issuing one access -> m1_gnt = 0 throughout; m1 granted the cycle after m0 lock falls.
REQ-035 Reset mid-operation: m0 read granted in cycle N, rst = 1 in cycle N+1 -> m0_rvalid = 0, all grants 0; after release, first contended grant goes to m0.
